// File: rtl/mips_pkg.sv
// Shared constants and arbiter FSM encoding for the register-file write path.
package mips_pkg;

  localparam int unsigned MIPS_AW    = 5;
  localparam int unsigned MIPS_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// In-order buffer of MDU write-back results with per-entry destination visibility.
module wb_result_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = MIPS_AW,
  parameter int unsigned WIDTH = MIPS_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [AW-1:0]             i_reg,
  input  logic [WIDTH-1:0]          i_data,
  output logic [AW-1:0]             o_head_reg,
  output logic [WIDTH-1:0]          o_head_data,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic [DEPTH-1:0]          o_ent_vld,
  output logic [DEPTH-1:0][AW-1:0]  o_ent_reg
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]            r_wptr;
  logic [PW-1:0]            r_rptr;
  logic [CW-1:0]            r_count;
  logic [DEPTH-1:0]         r_vld;
  logic [DEPTH-1:0][AW-1:0] r_reg;
  logic [WIDTH-1:0]         r_data [DEPTH];
  logic                     w_push;
  logic                     w_pop;

  assign w_push = i_push && (r_count < CW'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Pointers, occupancy and valid mask; push and pop never target the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_wptr        <= r_wptr + PW'(1);
        r_vld[r_wptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr        <= r_rptr + PW'(1);
        r_vld[r_rptr] <= 1'b0;
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_reg[r_wptr]  <= i_reg;
      r_data[r_wptr] <= i_data;
    end
  end

  assign o_head_reg  = r_reg[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;
  assign o_ent_vld   = r_vld;
  assign o_ent_reg   = r_reg;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline write-back and buffered MDU
// results; pipeline wins, a starvation counter forces a drain stall.
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned WIDTH        = MIPS_WIDTH,
  parameter int unsigned AW           = MIPS_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   W_regWrite_W,
  input  logic [AW-1:0]          W_writeReg_W,
  input  logic [WIDTH-1:0]       W_Result_W,
  input  logic                   mdu_valid,
  output logic                   mdu_ready,
  input  logic [AW-1:0]          mdu_reg,
  input  logic [WIDTH-1:0]       mdu_data,
  output logic                   rf_we,
  output logic [AW-1:0]          rf_wa,
  output logic [WIDTH-1:0]       rf_wd,
  output logic                   stall_o,
  input  logic [AW-1:0]          src_rs,
  input  logic [AW-1:0]          src_rt,
  output logic                   pend_hit,
  output logic [$clog2(DEPTH):0] buf_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e               r_state;
  arb_state_e               w_state_nxt;
  logic [SW-1:0]            r_starve;
  logic [SW-1:0]            w_starve_nxt;
  logic                     r_stall;
  logic                     w_pipe_req;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_pend_hit;
  logic [CW-1:0]            w_count;
  logic [CW-1:0]            w_count_nxt;
  logic [AW-1:0]            w_head_reg;
  logic [WIDTH-1:0]         w_head_data;
  logic [DEPTH-1:0]         w_ent_vld;
  logic [DEPTH-1:0][AW-1:0] w_ent_reg;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_reg       (mdu_reg),
    .i_data      (mdu_data),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_ent_vld   (w_ent_vld),
    .o_ent_reg   (w_ent_reg)
  );

  // Grant: pipeline first, then buffer head; nothing writes while in reset.
  assign w_pipe_req  = !rst && W_regWrite_W && (W_writeReg_W != '0);
  assign w_pop       = !rst && !w_pipe_req && (w_count != '0);
  assign mdu_ready   = !rst && (w_count < CW'(DEPTH));
  assign w_push      = mdu_valid && mdu_ready && (mdu_reg != '0);
  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  assign rf_we     = w_pipe_req || w_pop;
  assign rf_wa     = w_pipe_req ? W_writeReg_W : w_head_reg;
  assign rf_wd     = w_pipe_req ? W_Result_W : w_head_data;
  assign stall_o   = r_stall;
  assign buf_count = w_count;
  assign pend_hit  = w_pend_hit;

  always_comb begin
    w_pend_hit = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_ent_vld[i] && (w_ent_reg[i] != '0) &&
          ((w_ent_reg[i] == src_rs) || (w_ent_reg[i] == src_rt))) begin
        w_pend_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_starve <= '0;
      r_stall  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_stall  <= (w_state_nxt == ST_DRAIN);
    end
  end

  // Starvation counting and IDLE/PEND/DRAIN sequencing.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    if ((r_state == ST_DRAIN) || w_pop) begin
      w_starve_nxt = '0;
    end else if (w_pipe_req && (w_count != '0) && (r_starve < SW'(STARVE_LIMIT))) begin
      w_starve_nxt = r_starve + SW'(1);
    end
    unique case (r_state)
      ST_IDLE: begin
        if (w_push) w_state_nxt = ST_PEND;
      end
      ST_PEND: begin
        if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
        else if (w_starve_nxt >= SW'(STARVE_LIMIT)) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_count_nxt == '0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter; expected writes are queued as stimulus is
// issued and a negedge monitor matches every register-file write against them.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        W_regWrite_W;
  logic [4:0]  W_writeReg_W;
  logic [31:0] W_Result_W;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        stall_o;
  logic [4:0]  src_rs;
  logic [4:0]  src_rt;
  logic        pend_hit;
  logic [1:0]  buf_count;

  int  total = 0;
  int  bad   = 0;
  wr_t q_pipe[$];
  wr_t q_mdu[$];

  regfile_write_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4),
    .WIDTH        (32),
    .AW           (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .W_regWrite_W (W_regWrite_W),
    .W_writeReg_W (W_writeReg_W),
    .W_Result_W   (W_Result_W),
    .mdu_valid    (mdu_valid),
    .mdu_ready    (mdu_ready),
    .mdu_reg      (mdu_reg),
    .mdu_data     (mdu_data),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .stall_o      (stall_o),
    .src_rs       (src_rs),
    .src_rt       (src_rt),
    .pend_hit     (pend_hit),
    .buf_count    (buf_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One cycle of stimulus; expected writes are queued in the order they must appear.
  task automatic drive(input logic pw, input logic [4:0] pr, input logic [31:0] pd,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    W_regWrite_W = pw;
    W_writeReg_W = pr;
    W_Result_W   = pd;
    mdu_valid    = mv;
    mdu_reg      = mr;
    mdu_data     = md;
    if (pw && pr != 5'd0) q_pipe.push_back('{a: pr, d: pd});
    if (mv && mr != 5'd0) q_mdu.push_back('{a: mr, d: md});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: a pipeline request owns the port, otherwise any write is an MDU drain.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && W_regWrite_W && W_writeReg_W != 5'd0) begin
      total++;
      if (q_pipe.size() == 0) begin
        bad++;
        $display("FAIL wr_pipe: got we=%b wa=%0d wd=%0h want no queued write", rf_we, rf_wa, rf_wd);
      end else begin
        e = q_pipe.pop_front();
        if (!(rf_we === 1'b1 && rf_wa === e.a && rf_wd === e.d)) begin
          bad++;
          $display("FAIL wr_pipe: got we=%b wa=%0d wd=%0h want we=1 wa=%0d wd=%0h",
                   rf_we, rf_wa, rf_wd, e.a, e.d);
        end
      end
    end else if (rf_we !== 1'b0) begin
      total++;
      if (q_mdu.size() == 0) begin
        bad++;
        $display("FAIL wr_mdu: got we=%b wa=%0d wd=%0h want no write", rf_we, rf_wa, rf_wd);
      end else begin
        e = q_mdu.pop_front();
        if (!(rf_wa === e.a && rf_wd === e.d)) begin
          bad++;
          $display("FAIL wr_mdu: got wa=%0d wd=%0h want wa=%0d wd=%0h", rf_wa, rf_wd, e.a, e.d);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    src_rs = 5'd0;
    src_rt = 5'd0;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // 1: reset state, then ready once released
    tick();
    tick();
    @(negedge clk);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_ready", 32'(mdu_ready), 32'd0);
    chk("rst_count", 32'(buf_count), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(mdu_ready), 32'd1);
    tick();

    // 2: idle pipeline, single MDU result written the following cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("t2_count_n", 32'(buf_count), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t2_rf_we", 32'(rf_we), 32'd1);
    chk("t2_rf_wa", 32'(rf_wa), 32'd8);
    chk("t2_rf_wd", rf_wd, 32'hDEAD_BEEF);
    tick();
    chk("t2_count_after", 32'(buf_count), 32'd0);

    // 3: pipeline hogs the port, buffer fills, starvation forces a drain
    drive(1'b1, 5'd3, 32'h3000_0000, 1'b1, 5'd10, 32'hA000_0000);
    tick();
    drive(1'b1, 5'd3, 32'h3000_0001, 1'b1, 5'd11, 32'hA000_0001);
    @(negedge clk);
    chk("t3_count1", 32'(buf_count), 32'd1);
    tick();
    for (int k = 2; k <= 4; k++) begin
      drive(1'b1, 5'd3, 32'h3000_0000 + 32'(k), 1'b0, 5'd0, 32'd0);
      @(negedge clk);
      chk("t3_full_ready", 32'(mdu_ready), 32'd0);
      chk("t3_full_count", 32'(buf_count), 32'd2);
      chk("t3_no_stall_yet", 32'(stall_o), 32'd0);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t3_stall_on", 32'(stall_o), 32'd1);
    tick();
    @(negedge clk);
    chk("t3_stall_hold", 32'(stall_o), 32'd1);
    chk("t3_count_drain", 32'(buf_count), 32'd1);
    tick();
    chk("t3_stall_off", 32'(stall_o), 32'd0);
    chk("t3_count_empty", 32'(buf_count), 32'd0);

    // 4: push and pop every cycle at count 1, eight entries across pointer wrap
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd16 + 5'(k), 32'h4000_0000 + 32'(k));
      @(negedge clk);
      if (k > 0) chk("t4_count_pp", 32'(buf_count), 32'd1);
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t4_count_last", 32'(buf_count), 32'd1);
    tick();
    chk("t4_count_end", 32'(buf_count), 32'd0);

    // 5: reg-0 MDU result dropped; reg-0 pipeline write yields the port
    drive(1'b1, 5'd0, 32'h5555_5555, 1'b1, 5'd0, 32'hBAD0_0000);
    @(negedge clk);
    chk("t5_ready", 32'(mdu_ready), 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t5_drop_count", 32'(buf_count), 32'd0);
    chk("t5_drop_no_we", 32'(rf_we), 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0DE_0012);
    tick();
    drive(1'b1, 5'd0, 32'h6666_6666, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t5_zero_pipe_wa", 32'(rf_wa), 32'd12);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();

    // 6: pending-destination hits, then reset while full
    drive(1'b1, 5'd3, 32'h7000_0000, 1'b1, 5'd9, 32'hE000_0009);
    tick();
    drive(1'b1, 5'd3, 32'h7000_0001, 1'b1, 5'd7, 32'hE000_0007);
    src_rs = 5'd9;
    src_rt = 5'd0;
    @(negedge clk);
    chk("t6_hit_rs9", 32'(pend_hit), 32'd1);
    src_rs = 5'd0;
    src_rt = 5'd7;
    #1;
    chk("t6_rt7_not_yet", 32'(pend_hit), 32'd0);
    tick();
    drive(1'b1, 5'd3, 32'h7000_0002, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    chk("t6_hit_rt7", 32'(pend_hit), 32'd1);
    chk("t6_full_ready", 32'(mdu_ready), 32'd0);
    src_rs = 5'd0;
    src_rt = 5'd0;
    #1;
    chk("t6_zero_regs", 32'(pend_hit), 32'd0);
    tick();
    rst = 1'b1;
    q_mdu.delete();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    rst = 1'b0;
    src_rs = 5'd9;
    src_rt = 5'd7;
    @(negedge clk);
    chk("t6_rst_hit", 32'(pend_hit), 32'd0);
    chk("t6_rst_count", 32'(buf_count), 32'd0);
    tick();
    tick();
    tick();

    chk("end_pipe_q", 32'(q_pipe.size()), 32'd0);
    chk("end_mdu_q", 32'(q_mdu.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
